// File: rtl/binomial_frame_loader.sv
// rtl/binomial_frame_loader.sv - packs N serial W-bit words into a double-buffered N*W frame
module binomial_frame_loader #(
    parameter int N  = 10,
    parameter int W  = 16,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    output logic            in_ready,
    input  logic            clear,
    output logic [N*W-1:0]  array_val,
    output logic            array_valid,
    input  logic            array_ack,
    output logic [CW-1:0]   fill_count
);

    localparam logic [CW-1:0] C_FULL = CW'(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    logic [N*W-1:0] r_fill_buf;
    logic [CW-1:0]  r_fill_count;
    logic [N*W-1:0] r_array_val;
    logic           r_array_valid;

    logic           w_full;
    logic           w_accept;
    logic           w_last;
    logic           w_out_free;
    logic           w_park_xfer;
    logic           w_direct_xfer;
    logic [N*W-1:0] w_next_buf;

    assign w_full        = (r_fill_count == C_FULL);
    assign in_ready      = ~w_full;
    // clear drops any word offered in the same cycle
    assign w_accept      = in_valid & ~w_full & ~clear;
    assign w_last        = w_accept & (r_fill_count == C_LAST);
    assign w_out_free    = ~r_array_valid | array_ack;
    assign w_park_xfer   = w_full & r_array_valid & array_ack;
    assign w_direct_xfer = w_last & w_out_free;

    // slot 0 is the most significant word of the frame
    always_comb begin
        w_next_buf = r_fill_buf;
        for (int i = 0; i < N; i++) begin
            if (r_fill_count == CW'(i)) begin
                w_next_buf[(N-1-i)*W +: W] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_buf    <= '0;
            r_fill_count  <= '0;
            r_array_val   <= '0;
            r_array_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fill_buf <= w_next_buf;
            end

            if (w_park_xfer || w_direct_xfer || (clear && !w_full)) begin
                r_fill_count <= '0;
            end else if (w_last) begin
                r_fill_count <= C_FULL;
            end else if (w_accept) begin
                r_fill_count <= r_fill_count + 1'b1;
            end

            if (w_park_xfer) begin
                r_array_val   <= r_fill_buf;
                r_array_valid <= 1'b1;
            end else if (w_direct_xfer) begin
                r_array_val   <= w_next_buf;
                r_array_valid <= 1'b1;
            end else if (r_array_valid && array_ack) begin
                r_array_valid <= 1'b0;
            end
        end
    end

    assign array_val   = r_array_val;
    assign array_valid = r_array_valid;
    assign fill_count  = r_fill_count;

endmodule
